mfp_ahb_lite_master_port: RTL and testbench



---
 rtl/mfp_ahb_lite_master_port_pkg.sv | 14 +
 rtl/mfp_ahb_lite_master_port.sv | 94 +++++++++
 tb/tb_mfp_ahb_lite_master_port.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mfp_ahb_lite_master_port_pkg.sv
// mfp_ahb_lite_master_port_pkg: AHB-Lite encodings and local alignment check
package mfp_ahb_lite_master_port_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_8       = 3'd0;
  localparam logic [2:0] HSIZE_16      = 3'd1;
  localparam logic [2:0] HSIZE_32      = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  function automatic logic misaligned(input logic [1:0] addr, input logic [2:0] size);
    return (size > HSIZE_32) | ((size == HSIZE_16) & addr[0]) | ((size == HSIZE_32) & (addr != 2'b00));
  endfunction
endpackage

// File: rtl/mfp_ahb_lite_master_port.sv
// mfp_ahb_lite_master_port: valid/ready command stream to pipelined AHB-Lite SINGLE transfers
module mfp_ahb_lite_master_port
  import mfp_ahb_lite_master_port_pkg::*;
#(
  parameter logic [3:0] HPROT_VALUE = 4'b0011,
  parameter bit         CHECK_ALIGN = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);
  logic        r_ap_valid, r_ap_write, r_ap_lerr;
  logic [31:0] r_ap_addr, r_ap_wdata;
  logic [2:0]  r_ap_size;
  logic        r_dp_valid, r_dp_write, r_dp_lerr;
  logic [31:0] r_dp_wdata;
  logic        r_err1;
  logic        w_accept, w_cancel, w_lerr;
  assign cmd_ready = (~r_ap_valid | HREADY) & ~r_err1;
  assign w_accept  = cmd_valid & cmd_ready;
  // the entry behind an ERROR is dropped from the bus in the second error cycle
  assign w_cancel  = r_err1 & r_ap_valid;
  assign w_lerr    = CHECK_ALIGN & misaligned(cmd_addr[1:0], cmd_size);
  assign HTRANS    = (r_ap_valid & ~r_ap_lerr & ~w_cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = r_ap_addr;
  assign HWRITE    = r_ap_write;
  assign HSIZE     = r_ap_size;
  assign HWDATA    = r_dp_wdata;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VALUE;
  assign busy      = r_ap_valid | r_dp_valid;
  // address/data stage pipeline, ERROR tracking and response generation
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ap_valid <= 1'b0;
      r_ap_write <= 1'b0;
      r_ap_lerr  <= 1'b0;
      r_ap_addr  <= '0;
      r_ap_wdata <= '0;
      r_ap_size  <= '0;
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_lerr  <= 1'b0;
      r_dp_wdata <= '0;
      r_err1     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      if (HREADY) begin
        r_dp_valid <= r_ap_valid;
        r_dp_write <= r_ap_write;
        r_dp_wdata <= r_ap_wdata;
        r_dp_lerr  <= r_ap_lerr | w_cancel;
        rsp_valid  <= r_dp_valid;
        rsp_err    <= r_dp_valid & ((HRESP == HRESP_ERROR) | r_dp_lerr);
        rsp_rdata  <= (r_dp_valid & ~r_dp_write & ~r_dp_lerr) ? HRDATA : '0;
        r_err1     <= 1'b0;
      end else begin
        rsp_valid  <= 1'b0;
        r_err1     <= r_err1 | (r_dp_valid & (HRESP == HRESP_ERROR));
      end
      if (HREADY | ~r_ap_valid) r_ap_valid <= w_accept;
      if (w_accept) begin
        r_ap_addr  <= cmd_addr;
        r_ap_write <= cmd_write;
        r_ap_size  <= cmd_size;
        r_ap_wdata <= cmd_wdata;
        r_ap_lerr  <= w_lerr;
      end
    end
  end
endmodule

// File: tb/tb_mfp_ahb_lite_master_port.sv
// tb_mfp_ahb_lite_master_port: per-cycle vector table plus an async reset sequence
module tb_mfp_ahb_lite_master_port;
  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] N = 2'b10;
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [2:0]  cmd_size = '0;
  logic        cmd_ready, rsp_valid, rsp_err, busy, HMASTLOCK, HWRITE;
  logic [31:0] rsp_rdata, HADDR, HWDATA;
  logic [2:0]  HBURST, HSIZE;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1, HRESP = 1'b0;
  int total = 0, bad = 0;
  typedef struct {
    logic cv; logic [31:0] ca; logic cw; logic [2:0] cs; logic [31:0] cd;
    logic hr; logic hresp; logic [31:0] hrd;
    logic e_rdy; logic [1:0] e_tr;
    logic ck_a; logic [31:0] e_addr; logic e_hw;
    logic ck_w; logic [31:0] e_wd;
    logic e_rv; logic e_re; logic [31:0] e_rd; logic e_busy;
  } vec_t;
  vec_t v[$];
  mfp_ahb_lite_master_port dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );
  always #5 HCLK = ~HCLK;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic add(input logic cv, input logic [31:0] ca, input logic cw, input logic [2:0] cs,
                     input logic [31:0] cd, input logic hr, input logic hresp, input logic [31:0] hrd,
                     input logic e_rdy, input logic [1:0] e_tr, input logic ck_a, input logic [31:0] e_addr,
                     input logic e_hw, input logic ck_w, input logic [31:0] e_wd, input logic e_rv,
                     input logic e_re, input logic [31:0] e_rd, input logic e_busy);
    v.push_back('{cv, ca, cw, cs, cd, hr, hresp, hrd, e_rdy, e_tr, ck_a, e_addr, e_hw, ck_w, e_wd,
                  e_rv, e_re, e_rd, e_busy});
  endtask
  task automatic drive(input logic cv, input logic [31:0] ca, input logic cw, input logic [2:0] cs,
                       input logic [31:0] cd, input logic hr, input logic hresp, input logic [31:0] hrd);
    cmd_valid = cv; cmd_addr = ca; cmd_write = cw; cmd_size = cs; cmd_wdata = cd;
    HREADY = hr; HRESP = hresp; HRDATA = hrd;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    // single read, zero wait
    add(1,32'h80000010,0,2,0,          1,0,0,            1,I,0,0,0,0,0,                        0,0,0,0);
    add(0,0,0,0,0,                     1,0,0,            1,N,1,32'h80000010,0,0,0,             0,0,0,1);
    add(0,0,0,0,0,                     1,0,32'hDEADBEEF, 1,I,0,0,0,0,0,                        0,0,0,1);
    add(0,0,0,0,0,                     1,0,0,            1,I,0,0,0,0,0,                        1,0,32'hDEADBEEF,0);
    // four back-to-back writes
    add(1,32'h80000000,1,2,32'hA0000000, 1,0,0,          1,I,0,0,0,0,0,                        0,0,0,0);
    add(1,32'h80000004,1,2,32'hA0000001, 1,0,0,          1,N,1,32'h80000000,1,0,0,             0,0,0,1);
    add(1,32'h80000008,1,2,32'hA0000002, 1,0,0,          1,N,1,32'h80000004,1,1,32'hA0000000,  0,0,0,1);
    add(1,32'h8000000C,1,2,32'hA0000003, 1,0,0,          1,N,1,32'h80000008,1,1,32'hA0000001,  1,0,0,1);
    add(0,0,0,0,0,                     1,0,0,            1,N,1,32'h8000000C,1,1,32'hA0000002,  1,0,0,1);
    add(0,0,0,0,0,                     1,0,0,            1,I,0,0,0,1,32'hA0000003,             1,0,0,1);
    add(0,0,0,0,0,                     1,0,0,            1,I,0,0,0,0,0,                        1,0,0,0);
    add(0,0,0,0,0,                     1,0,0,            1,I,0,0,0,0,0,                        0,0,0,0);
    // read with three wait states while a second and third command queue up
    add(1,32'h80000020,0,2,0,          1,0,0,            1,I,0,0,0,0,0,                        0,0,0,0);
    add(1,32'h80000024,0,2,0,          1,0,0,            1,N,1,32'h80000020,0,0,0,             0,0,0,1);
    add(1,32'h80000028,0,2,0,          0,0,0,            0,N,1,32'h80000024,0,0,0,             0,0,0,1);
    add(1,32'h80000028,0,2,0,          0,0,0,            0,N,1,32'h80000024,0,0,0,             0,0,0,1);
    add(1,32'h80000028,0,2,0,          0,0,0,            0,N,1,32'h80000024,0,0,0,             0,0,0,1);
    add(1,32'h80000028,0,2,0,          1,0,32'h12345678, 1,N,1,32'h80000024,0,0,0,             0,0,0,1);
    add(0,0,0,0,0,                     1,0,32'h9ABCDEF0, 1,N,1,32'h80000028,0,0,0,             1,0,32'h12345678,1);
    add(0,0,0,0,0,                     1,0,32'h0F0F0F0F, 1,I,0,0,0,0,0,                        1,0,32'h9ABCDEF0,1);
    add(0,0,0,0,0,                     1,0,0,            1,I,0,0,0,0,0,                        1,0,32'h0F0F0F0F,0);
    add(0,0,0,0,0,                     1,0,0,            1,I,0,0,0,0,0,                        0,0,0,0);
    // misaligned half-word write rejected locally, then a good read
    add(1,32'h80000001,1,1,32'h0000BEEF, 1,0,0,          1,I,0,0,0,0,0,                        0,0,0,0);
    add(1,32'h80000030,0,2,0,          1,0,0,            1,I,0,0,0,0,0,                        0,0,0,1);
    add(0,0,0,0,0,                     1,0,32'h55AA55AA, 1,N,1,32'h80000030,0,0,0,             0,0,0,1);
    add(0,0,0,0,0,                     1,0,32'hCAFEF00D, 1,I,0,0,0,0,0,                        1,1,0,1);
    add(0,0,0,0,0,                     1,0,0,            1,I,0,0,0,0,0,                        1,0,32'hCAFEF00D,0);
    // ERROR on the first of two pipelined reads
    add(1,32'h80000040,0,2,0,          1,0,0,            1,I,0,0,0,0,0,                        0,0,0,0);
    add(1,32'h80000044,0,2,0,          1,0,0,            1,N,1,32'h80000040,0,0,0,             0,0,0,1);
    add(0,0,0,0,0,                     0,1,0,            0,N,1,32'h80000044,0,0,0,             0,0,0,1);
    add(1,32'h80000048,0,2,0,          1,1,0,            0,I,0,0,0,0,0,                        0,0,0,1);
    add(1,32'h80000048,0,2,0,          1,0,0,            1,I,0,0,0,0,0,                        1,1,0,1);
    add(0,0,0,0,0,                     1,0,0,            1,N,1,32'h80000048,0,0,0,             1,1,0,1);
    add(0,0,0,0,0,                     1,0,32'h13572468, 1,I,0,0,0,0,0,                        0,0,0,1);
    add(0,0,0,0,0,                     1,0,0,            1,I,0,0,0,0,0,                        1,0,32'h13572468,0);
    add(0,0,0,0,0,                     1,0,0,            1,I,0,0,0,0,0,                        0,0,0,0);
    // misaligned word write rejected locally
    add(1,32'h80000002,1,2,0,          1,0,0,            1,I,0,0,0,0,0,                        0,0,0,0);
    add(0,0,0,0,0,                     1,0,0,            1,I,0,0,0,0,0,                        0,0,0,1);
    add(0,0,0,0,0,                     1,0,32'h77777777, 1,I,0,0,0,0,0,                        0,0,0,1);
    add(0,0,0,0,0,                     1,0,0,            1,I,0,0,0,0,0,                        1,1,0,0);
    // reset state
    repeat (2) @(negedge HCLK);
    #1;
    chk("rst_htrans", 32'(HTRANS), 32'(I));
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hprot", 32'(HPROT), 32'h3);
    chk("rst_hburst", 32'(HBURST), 0);
    chk("rst_hmastlock", 32'(HMASTLOCK), 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    foreach (v[k]) begin
      @(negedge HCLK);
      drive(v[k].cv, v[k].ca, v[k].cw, v[k].cs, v[k].cd, v[k].hr, v[k].hresp, v[k].hrd);
      #1;
      chk($sformatf("c%0d cmd_ready", k), 32'(cmd_ready), 32'(v[k].e_rdy));
      chk($sformatf("c%0d htrans", k), 32'(HTRANS), 32'(v[k].e_tr));
      chk($sformatf("c%0d busy", k), 32'(busy), 32'(v[k].e_busy));
      chk($sformatf("c%0d rsp_valid", k), 32'(rsp_valid), 32'(v[k].e_rv));
      if (v[k].ck_a) begin
        chk($sformatf("c%0d haddr", k), HADDR, v[k].e_addr);
        chk($sformatf("c%0d hwrite", k), 32'(HWRITE), 32'(v[k].e_hw));
      end
      if (v[k].ck_w) chk($sformatf("c%0d hwdata", k), HWDATA, v[k].e_wd);
      if (v[k].e_rv) begin
        chk($sformatf("c%0d rsp_err", k), 32'(rsp_err), 32'(v[k].e_re));
        chk($sformatf("c%0d rsp_rdata", k), rsp_rdata, v[k].e_rd);
      end
    end
    // async reset during a waited data phase drops both in-flight reads
    @(negedge HCLK);
    drive(1, 32'h80000050, 0, 2, 0, 1, 0, 0);
    @(negedge HCLK);
    drive(1, 32'h80000054, 0, 2, 0, 1, 0, 0);
    @(negedge HCLK);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_htrans", 32'(HTRANS), 32'(N));
    chk("pre_rst_haddr", HADDR, 32'h80000054);
    #2 HRESET = 1'b1;
    #1;
    chk("arst_htrans", 32'(HTRANS), 32'(I));
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_haddr", HADDR, 0);
    chk("arst_hwdata", HWDATA, 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      #1;
      chk($sformatf("post_rst%0d rsp_valid", k), 32'(rsp_valid), 0);
    end
    @(negedge HCLK);
    drive(1, 32'h80000060, 0, 2, 0, 1, 0, 0);
    @(negedge HCLK);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("new_htrans", 32'(HTRANS), 32'(N));
    chk("new_haddr", HADDR, 32'h80000060);
    @(negedge HCLK);
    drive(0, 0, 0, 0, 0, 1, 0, 32'h2468ACE0);
    @(negedge HCLK);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("new_rsp_valid", 32'(rsp_valid), 1);
    chk("new_rsp_err", 32'(rsp_err), 0);
    chk("new_rsp_rdata", rsp_rdata, 32'h2468ACE0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
